// File: rtl/simon_sequence.sv
// simon_sequence: Simon colour pattern store filled from a free-running LFSR,
// with display/input index I, round-length index J and one-hot colour decode.
module simon_sequence #(
    parameter int          MAX_LEN = 16,
    parameter int          IDX_W   = 4,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic START,
    input  logic I_en,
    input  logic I_cl,
    input  logic J_en,
    input  logic J_cl,
    output logic rand_done,
    output logic I_eq_J,
    output logic J_max,
    output logic yello,
    output logic re,
    output logic blu,
    output logic gree
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(MAX_LEN - 1);

    state_t           state, state_nx;
    logic [15:0]      lfsr, lfsr_nx;
    logic [IDX_W-1:0] wr_ptr, I, J;
    logic [1:0]       mem [MAX_LEN];
    logic [1:0]       col;
    logic             last_wr, done;

    // An all-zero LFSR would lock up, so it reseeds instead.
    assign lfsr_nx = (lfsr == 16'h0) ? SEED : ((lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000));
    assign last_wr = wr_ptr == LAST;

    always_comb begin
        state_nx = START ? FILL : (state == FILL && last_wr) ? DONE : state;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            rand_done <= 1'b0;
            lfsr      <= SEED;
            wr_ptr    <= '0;
        end else begin
            state     <= state_nx;
            rand_done <= state_nx == DONE;
            lfsr      <= lfsr_nx;
            wr_ptr    <= (START || (state == FILL && last_wr)) ? '0 : (state == FILL) ? wr_ptr + 1'b1 : wr_ptr;
        end
    end

    // A START seen mid-fill restarts the fill without writing on that edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < MAX_LEN; k++) mem[k] <= 2'b00;
        end else if (state == FILL && !START) begin
            mem[wr_ptr] <= lfsr[1:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            I <= '0;
            J <= '0;
        end else begin
            I <= I_cl ? '0 : I_en ? ((I == LAST) ? '0 : I + 1'b1) : I;
            J <= J_cl ? '0 : (J_en && !J_max) ? J + 1'b1 : J;
        end
    end

    assign I_eq_J = I == J;
    assign J_max  = J == LAST;
    assign done   = state == DONE;
    assign col    = mem[I];
    assign yello  = done && col == 2'b00;
    assign re     = done && col == 2'b01;
    assign blu    = done && col == 2'b10;
    assign gree   = done && col == 2'b11;
endmodule
